// File: rtl/md5_candidate_gen.sv
// Candidate-message feeder for the MD5 brute-force core: odometer enumeration
// over [CHAR_FIRST..CHAR_LAST], lengths start_len..MAX_LEN, with a ready/valid offer.
module md5_candidate_gen #(
  parameter int unsigned MAX_LEN    = 8,
  parameter logic [7:0]  CHAR_FIRST = 8'h61,
  parameter logic [7:0]  CHAR_LAST  = 8'h7A
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [4:0]     start_len_i,
  input  logic           abort_i,
  input  logic           core_ready_i,
  output logic [127:0]   cand_msg_o,
  output logic [7:0]     cand_width_o,
  output logic           cand_valid_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [31:0]    cand_count_o
);

  localparam int unsigned LEN_W     = 5;
  localparam int unsigned MSG_W     = 128;
  localparam int unsigned MSG_BYTES = 16;
  localparam int unsigned WIDTH_W   = 8;
  localparam int unsigned CNT_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAITRDY, S_OFFER, S_ADVANCE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MSG_W-1:0]   inc_msg;
  logic               inc_carry;
  logic               xfer;

  // Character k sits in the k-th byte from the MSB (left-aligned message).
  function automatic logic [MSG_W-1:0] fill_first(input logic [LEN_W-1:0] l);
    logic [MSG_W-1:0] m;
    m = '0;
    for (int k = 0; k < int'(MSG_BYTES); k++) begin
      if (k < int'(l)) m[MSG_W-1-8*k -: 8] = CHAR_FIRST;
    end
    return m;
  endfunction

  function automatic logic [MSG_W-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MSG_W-1:0] m;
    m = '0;
    for (int k = 0; k < int'(MSG_BYTES); k++) begin
      if (k < int'(l)) m[MSG_W-1-8*k -: 8] = 8'hFF;
    end
    return m;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)                 return LEN_W'(1);
    else if (32'(l) > MAX_LEN)   return LEN_W'(MAX_LEN);
    else                         return l;
  endfunction

  // Odometer increment: rightmost active character moves fastest.
  always_comb begin
    inc_msg   = msg_q;
    inc_carry = 1'b1;
    for (int k = int'(MSG_BYTES) - 1; k >= 0; k--) begin
      if (inc_carry && (k < int'(len_q))) begin
        if (inc_msg[MSG_W-1-8*k -: 8] == CHAR_LAST) begin
          inc_msg[MSG_W-1-8*k -: 8] = CHAR_FIRST;
        end else begin
          inc_msg[MSG_W-1-8*k -: 8] = inc_msg[MSG_W-1-8*k -: 8] + 8'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  assign xfer = (state_q == S_OFFER) && core_ready_i;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    msg_d   = msg_q;
    width_d = width_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    count_d = count_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
          len_d   = clamp_len(start_len_i);
          count_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_LOAD: begin
        msg_d   = fill_first(len_q);
        width_d = {len_q, 3'b000};
        state_d = S_WAITRDY;
      end
      S_WAITRDY: begin
        if (core_ready_i) begin
          valid_d = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        valid_d = 1'b0;
        if (core_ready_i) begin
          count_d = count_q + CNT_W'(1);
          state_d = S_ADVANCE;
        end else begin
          state_d = S_WAITRDY;
        end
      end
      S_ADVANCE: begin
        if (!inc_carry) begin
          msg_d   = inc_msg;
          state_d = S_WAITRDY;
        end else if (32'(len_q) == MAX_LEN) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          len_d   = LEN_W'(len_q + LEN_W'(1));
          msg_d   = fill_first(LEN_W'(len_q + LEN_W'(1)));
          width_d = {LEN_W'(len_q + LEN_W'(1)), 3'b000};
          state_d = S_WAITRDY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats start, but a same-edge transfer still counts.
    if (abort_i) begin
      state_d = S_IDLE;
      len_d   = len_q;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      count_d = xfer ? count_q + CNT_W'(1) : count_q;
    end

    msg_d = msg_d & len_mask(len_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      msg_q   <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      msg_q   <= msg_d;
      width_q <= width_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign cand_msg_o   = msg_q;
  assign cand_width_o = width_q;
  assign cand_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cand_count_o = count_q;

endmodule

// File: tb/tb_md5_candidate_gen.sv
// Directed bench for md5_candidate_gen with MAX_LEN=2 over 'a'..'c'.
module tb_md5_candidate_gen;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [4:0]   start_len;
  logic         abort;
  logic         core_ready;
  logic [127:0] cand_msg;
  logic [7:0]   cand_width;
  logic         cand_valid;
  logic         busy;
  logic         done;
  logic [31:0]  cand_count;

  int n_vec = 0;
  int n_err = 0;

  md5_candidate_gen #(
    .MAX_LEN   (2),
    .CHAR_FIRST(8'h61),
    .CHAR_LAST (8'h63)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .start_len_i  (start_len),
    .abort_i      (abort),
    .core_ready_i (core_ready),
    .cand_msg_o   (cand_msg),
    .cand_width_o (cand_width),
    .cand_valid_o (cand_valid),
    .busy_o       (busy),
    .done_o       (done),
    .cand_count_o (cand_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] msg;
    logic [7:0]   width;
  } cand_t;

  typedef struct {
    logic [4:0]   slen;
    logic [127:0] msg;
    logic [7:0]   width;
  } first_vec_t;

  cand_t      seq_tbl [12];
  first_vec_t first_tbl [4];

  function automatic logic [127:0] m1(input logic [7:0] c0);
    return {c0, 120'h0};
  endfunction

  function automatic logic [127:0] m2(input logic [7:0] c0, input logic [7:0] c1);
    return {c0, c1, 112'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Returns positioned just before an edge where valid && ready (a transfer).
  task automatic wait_xfer(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (cand_valid && core_ready) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting for transfer, got none want one", name);
  endtask

  task automatic pulse_start(input logic [4:0] l);
    start_len = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int vh;
    logic [7:0] ch [3];
    ch[0] = 8'h61; ch[1] = 8'h62; ch[2] = 8'h63;

    for (int i = 0; i < 3; i++) begin
      seq_tbl[i].msg   = m1(ch[i]);
      seq_tbl[i].width = 8'd8;
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        seq_tbl[3 + 3*i + j].msg   = m2(ch[i], ch[j]);
        seq_tbl[3 + 3*i + j].width = 8'd16;
      end
    end
    first_tbl[0] = '{5'd1,  m1(8'h61),        8'd8};
    first_tbl[1] = '{5'd0,  m1(8'h61),        8'd8};
    first_tbl[2] = '{5'd20, m2(8'h61, 8'h61), 8'd16};
    first_tbl[3] = '{5'd2,  m2(8'h61, 8'h61), 8'd16};

    rst_n = 1'b0; start = 1'b0; start_len = '0; abort = 1'b0; core_ready = 1'b0;
    #22;
    chk("rst_msg",   cand_msg,   128'h0);
    chk("rst_width", cand_width, 0);
    chk("rst_valid", cand_valid, 0);
    chk("rst_busy",  busy,       0);
    chk("rst_done",  done,       0);
    chk("rst_count", cand_count, 0);
    rst_n = 1'b1;
    tick();

    // First candidate for each start_len, then abort on the transfer edge.
    core_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      pulse_start(first_tbl[v].slen);
      wait_xfer("first_wait", ok);
      if (ok) begin
        chk("first_msg",   cand_msg,   first_tbl[v].msg);
        chk("first_width", cand_width, first_tbl[v].width);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("first_abort_count", cand_count, 1);
      chk("first_abort_busy",  busy,       0);
    end

    // Full run with a slow core; a stray start mid-run must be ignored.
    pulse_start(5'd1);
    for (int i = 0; i < 12; i++) begin
      core_ready = 1'b1;
      wait_xfer("run_wait", ok);
      if (ok) begin
        chk("run_msg",   cand_msg,   seq_tbl[i].msg);
        chk("run_width", cand_width, seq_tbl[i].width);
      end
      tick();
      chk("run_count", cand_count, 32'(i + 1));
      chk("run_valid_drop", cand_valid, 0);
      core_ready = 1'b0;
      if (i == 3) pulse_start(5'd2);
      repeat (15) tick();
    end
    chk("run_done",  done,       1);
    chk("run_busy",  busy,       0);
    chk("run_count_final", cand_count, 12);
    chk("run_hold_msg",   cand_msg,   m2(8'h63, 8'h63));
    chk("run_hold_width", cand_width, 16);

    // Restart from DONE, then abort on the 6th transfer.
    pulse_start(5'd0);
    chk("restart_done",  done,       0);
    chk("restart_busy",  busy,       1);
    chk("restart_count", cand_count, 0);
    core_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_xfer("abort_wait", ok);
      tick();
    end
    wait_xfer("abort_wait6", ok);
    if (ok) chk("abort_msg6", cand_msg, m2(8'h61, 8'h63));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", cand_valid, 0);
    chk("abort_busy",  busy,       0);
    chk("abort_done",  done,       0);
    chk("abort_count", cand_count, 6);
    tick();
    chk("abort_idle_valid", cand_valid, 0);

    // Core holds off for 40 cycles.
    core_ready = 1'b0;
    pulse_start(5'd20);
    vh = 0;
    repeat (40) begin
      tick();
      if (cand_valid) vh++;
    end
    chk("hs_valid_low", vh, 0);
    chk("hs_count0", cand_count, 0);
    core_ready = 1'b1;
    tick();
    chk("hs_valid_rise", cand_valid, 1);
    chk("hs_msg",   cand_msg,   m2(8'h61, 8'h61));
    chk("hs_width", cand_width, 16);
    tick();
    chk("hs_count1", cand_count, 1);
    chk("hs_valid_drop", cand_valid, 0);

    // Asynchronous reset while offering.
    wait_xfer("rst_wait", ok);
    rst_n = 1'b0;
    #1;
    chk("arst_msg",   cand_msg,   128'h0);
    chk("arst_width", cand_width, 0);
    chk("arst_valid", cand_valid, 0);
    chk("arst_busy",  busy,       0);
    chk("arst_done",  done,       0);
    chk("arst_count", cand_count, 0);
    #1;
    rst_n = 1'b1;
    vh = 0;
    repeat (6) begin
      tick();
      if (cand_valid || busy) vh++;
    end
    chk("arst_idle", vh, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
